// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light safety monitor: tracked phases,
// fault codes, per-direction lamp decode values and the legal phase-step table.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_INIT = 3'd0,
        PH_NS_G = 3'd1,
        PH_NS_Y = 3'd2,
        PH_AR_A = 3'd3,
        PH_EW_G = 3'd4,
        PH_EW_Y = 3'd5,
        PH_AR_B = 3'd6
    } phase_e;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_ORDER    = 3'd3;
    localparam logic [2:0] FC_YELLOW   = 3'd4;
    localparam logic [2:0] FC_GREEN    = 3'd5;
    localparam logic [2:0] FC_ALLRED   = 3'd6;

    typedef enum logic [1:0] {
        LAMP_R       = 2'd0,
        LAMP_Y       = 2'd1,
        LAMP_G       = 2'd2,
        LAMP_ILLEGAL = 2'd3
    } lamp_e;

    // skip_ok allows the yellow phase to hand over directly to the other green.
    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph,
                                        input logic skip_ok);
        logic ok;
        ok = 1'b0;
        case (from_ph)
            PH_NS_G: ok = (to_ph == PH_NS_Y);
            PH_NS_Y: ok = (to_ph == PH_AR_A) || (skip_ok && (to_ph == PH_EW_G));
            PH_AR_A: ok = (to_ph == PH_EW_G);
            PH_EW_G: ok = (to_ph == PH_EW_Y);
            PH_EW_Y: ok = (to_ph == PH_AR_B) || (skip_ok && (to_ph == PH_NS_G));
            PH_AR_B: ok = (to_ph == PH_NS_G);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_safety_monitor_lamp_decode.sv
// Combinational decode of one direction's red/yellow/green lines; anything
// other than exactly one lit lamp is reported as illegal.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic  red_i,
    input  logic  yellow_i,
    input  logic  green_i,
    output lamp_e lamp_o
);

    always_comb begin
        lamp_o = LAMP_ILLEGAL;
        case ({red_i, yellow_i, green_i})
            3'b100:  lamp_o = LAMP_R;
            3'b010:  lamp_o = LAMP_Y;
            3'b001:  lamp_o = LAMP_G;
            default: lamp_o = LAMP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Passive lamp-output checker: tracks the NS/EW phase sequence and dwell times
// and latches a sticky code for the first violation, resyncing to INIT on any fault.
module traffic_safety_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN     = 5,
    parameter int GREEN_MAX     = 20,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_MIN    = 0,
    parameter int ALLRED_MAX    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ns_red_i,
    input  logic        ns_yellow_i,
    input  logic        ns_green_i,
    input  logic        ew_red_i,
    input  logic        ew_yellow_i,
    input  logic        ew_green_i,
    input  logic        clear_i,
    output logic        fault_o,
    output logic [2:0]  fault_code_o,
    output logic [2:0]  phase_o,
    output logic [4:0]  dwell_o,
    output logic [15:0] cycle_count_o
);

    lamp_e ns_lamp;
    lamp_e ew_lamp;

    lamp_decode u_ns_decode (
        .red_i    (ns_red_i),
        .yellow_i (ns_yellow_i),
        .green_i  (ns_green_i),
        .lamp_o   (ns_lamp)
    );

    lamp_decode u_ew_decode (
        .red_i    (ew_red_i),
        .yellow_i (ew_yellow_i),
        .green_i  (ew_green_i),
        .lamp_o   (ew_lamp)
    );

    phase_e      phase_q, phase_d;
    logic [4:0]  dwell_q, dwell_d;
    logic        first_green_q, first_green_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic [15:0] count_q, count_d;

    phase_e      obs_phase;
    logic [2:0]  viol;
    int          dwell_int;

    // Map the sampled lamp pair to the phase it represents; all-red belongs to
    // whichever direction just finished.
    always_comb begin
        obs_phase = PH_INIT;
        if (ns_lamp == LAMP_G && ew_lamp == LAMP_R)      obs_phase = PH_NS_G;
        else if (ns_lamp == LAMP_Y && ew_lamp == LAMP_R) obs_phase = PH_NS_Y;
        else if (ns_lamp == LAMP_R && ew_lamp == LAMP_G) obs_phase = PH_EW_G;
        else if (ns_lamp == LAMP_R && ew_lamp == LAMP_Y) obs_phase = PH_EW_Y;
        else if (ns_lamp == LAMP_R && ew_lamp == LAMP_R)
            obs_phase = (phase_q == PH_EW_Y || phase_q == PH_AR_B) ? PH_AR_B : PH_AR_A;
    end

    always_comb begin
        viol          = FC_NONE;
        phase_d       = phase_q;
        dwell_d       = dwell_q;
        first_green_d = first_green_q;
        count_d       = count_q;
        dwell_int     = int'(dwell_q);

        if (ns_lamp == LAMP_ILLEGAL || ew_lamp == LAMP_ILLEGAL) begin
            viol = FC_ILLEGAL;
        end else if (ns_lamp != LAMP_R && ew_lamp != LAMP_R) begin
            viol = FC_CONFLICT;
        end else if (phase_q == PH_INIT) begin
            if (obs_phase == PH_NS_G || obs_phase == PH_EW_G) begin
                phase_d       = obs_phase;
                dwell_d       = 5'd1;
                first_green_d = 1'b1;
            end
        end else if (obs_phase == phase_q) begin
            case (phase_q)
                PH_NS_Y, PH_EW_Y: if (dwell_int == YELLOW_CYCLES) viol = FC_YELLOW;
                PH_NS_G, PH_EW_G: if (dwell_int == GREEN_MAX)     viol = FC_GREEN;
                default:          if (dwell_int == ALLRED_MAX)    viol = FC_ALLRED;
            endcase
            dwell_d = (dwell_q == 5'd31) ? dwell_q : dwell_q + 5'd1;
        end else if (!legal_step(phase_q, obs_phase, ALLRED_MIN == 0)) begin
            viol = FC_ORDER;
        end else begin
            // Legal exit: the phase being left must have met its minimum dwell.
            case (phase_q)
                PH_NS_Y, PH_EW_Y: if (dwell_int < YELLOW_CYCLES) viol = FC_YELLOW;
                PH_NS_G, PH_EW_G: if (!first_green_q && dwell_int < GREEN_MIN) viol = FC_GREEN;
                default:          if (dwell_int < ALLRED_MIN) viol = FC_ALLRED;
            endcase
            phase_d       = obs_phase;
            dwell_d       = 5'd1;
            first_green_d = 1'b0;
            if (obs_phase == PH_NS_G) count_d = count_q + 16'd1;
        end

        if (viol != FC_NONE) begin
            phase_d       = PH_INIT;
            dwell_d       = 5'd0;
            first_green_d = 1'b0;
            count_d       = count_q;
        end
    end

    // A violation coinciding with clear_i wins over the clear.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        if (clear_i) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
        if (viol != FC_NONE && (!fault_q || clear_i)) begin
            fault_d = 1'b1;
            code_d  = viol;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q       <= PH_INIT;
            dwell_q       <= 5'd0;
            first_green_q <= 1'b0;
            fault_q       <= 1'b0;
            code_q        <= FC_NONE;
            count_q       <= 16'd0;
        end else begin
            phase_q       <= phase_d;
            dwell_q       <= dwell_d;
            first_green_q <= first_green_d;
            fault_q       <= fault_d;
            code_q        <= code_d;
            count_q       <= count_d;
        end
    end

    assign fault_o       = fault_q;
    assign fault_code_o  = code_q;
    assign phase_o       = phase_q;
    assign dwell_o       = dwell_q;
    assign cycle_count_o = count_q;

endmodule
